ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register of the 16-bit pipelined processor.
- Consumes the ID/EX register outputs, applies the forwarding selects from the hazard unit, and performs the ALU operation with S/Z/C/V flag generation.
- Registers the result and the surviving control bits for the MEM stage.
- Holds or bubbles on request from the hazard unit.

---
 rtl/ex_mem_stage.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// Execute stage of the 16-bit pipelined processor and the EX/MEM pipeline
// register that follows it. The stage resolves operand forwarding, selects the
// ALU sources, computes the result and the S/Z/C/V flags, and registers the
// result and the control bits that the MEM stage still needs.
//
// Optional feature, macro EX_MUL_EN:
//   defined   - op 12 is a 16-cycle iterative shift-add multiply that stalls
//               the stage through a small IDLE/BUSY/DONE state machine.
//   undefined - op 12 behaves as MOV and stall_ex is tied low.

module ex_mem_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             ex_mem_write,
    input  logic             flush,

    input  logic [WIDTH-1:0] program_counter_pre_ex,
    input  logic [1:0]       op_alu_src_a_ex,
    input  logic [1:0]       op_alu_src_b_ex,
    input  logic [3:0]       op_alu_ex,
    input  logic             op_mem_write_ex,
    input  logic             op_mem_read_ex,
    input  logic             op_reg_write_ex,
    input  logic             op_reg_write_address_ex,
    input  logic             op_mdr_ex,
    input  logic             op_res_ex,
    input  logic [2:0]       rs_ex,
    input  logic [2:0]       rd_ex,
    input  logic [WIDTH-1:0] ar_ex,
    input  logic [WIDTH-1:0] br_ex,
    input  logic [WIDTH-1:0] instruction_register_ex,

    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [WIDTH-1:0] fwd_mem_data,
    input  logic [WIDTH-1:0] fwd_wb_data,

    output logic             op_mem_write_mem,
    output logic             op_mem_read_mem,
    output logic             op_reg_write_mem,
    output logic             op_reg_write_address_mem,
    output logic             op_mdr_mem,
    output logic             op_res_mem,
    output logic [2:0]       rd_mem,
    output logic [WIDTH-1:0] alu_result_mem,
    output logic [WIDTH-1:0] store_data_mem,
    output logic [WIDTH-1:0] program_counter_pre_mem,
    output logic [WIDTH-1:0] instruction_register_mem,
    output logic [3:0]       flags,
    output logic             stall_ex
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SLR = 4'd9;
    localparam logic [3:0] ALU_SRL = 4'd10;
    localparam logic [3:0] ALU_SRA = 4'd11;

    // rs_ex is consumed by the hazard unit, not by this stage.
    logic unused_rs;
    assign unused_rs = ^rs_ex;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    // Forwarding muxes followed by the ALU source muxes.
    always_comb begin
        // NOTE: every case below ends in a default, so each output is assigned
        // on every path and no latch can be inferred.
        case (fwd_a_sel)
            2'b01:   fwd_a = fwd_mem_data;
            2'b10:   fwd_a = fwd_wb_data;
            default: fwd_a = ar_ex;
        endcase

        case (fwd_b_sel)
            2'b01:   fwd_b = fwd_mem_data;
            2'b10:   fwd_b = fwd_wb_data;
            default: fwd_b = br_ex;
        endcase

        case (op_alu_src_a_ex)
            2'b00:   opnd_a = fwd_a;
            2'b01:   opnd_a = program_counter_pre_ex;
            default: opnd_a = '0;
        endcase

        case (op_alu_src_b_ex)
            2'b00:   opnd_b = fwd_b;
            2'b01:   opnd_b = {{(WIDTH-8){instruction_register_ex[7]}},
                               instruction_register_ex[7:0]};
            2'b10:   opnd_b = {{(WIDTH-4){1'b0}}, instruction_register_ex[3:0]};
            default: opnd_b = {{(WIDTH-1){1'b0}}, 1'b1};
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [3:0]              shamt;
    logic [WIDTH:0]          add_wide;
    logic [WIDTH:0]          sub_wide;
    logic [WIDTH:0]          sll_wide;
    logic [WIDTH:0]          srl_wide;
    logic signed [WIDTH:0]   sra_wide;
    logic [WIDTH-1:0]        rot_res;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c;
    logic                    alu_v;
    logic [3:0]              alu_flags;
    logic                    flag_op;

    // The extra bit on each wide result holds carry/borrow or the last bit
    // shifted out; an amount of zero leaves it clear automatically.
    assign shamt    = opnd_b[3:0];
    assign add_wide = {1'b0, opnd_a} + {1'b0, opnd_b};
    assign sub_wide = {1'b0, opnd_a} - {1'b0, opnd_b};
    assign sll_wide = {1'b0, opnd_a} << shamt;
    assign srl_wide = {opnd_a, 1'b0} >> shamt;
    assign sra_wide = $signed({opnd_a, 1'b0}) >>> shamt;
    assign rot_res  = (opnd_a << shamt) | (opnd_a >> (5'd16 - {1'b0, shamt}));

    // Result, carry and overflow per operation; unknown codes fall back to MOV.
    always_comb begin
        alu_res = opnd_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_alu_ex)
            ALU_ADD: begin
                alu_res = add_wide[WIDTH-1:0];
                alu_c   = add_wide[WIDTH];
                alu_v   = (opnd_a[WIDTH-1] == opnd_b[WIDTH-1]) &&
                          (add_wide[WIDTH-1] != opnd_a[WIDTH-1]);
            end
            ALU_SUB, ALU_CMP: begin
                alu_res = sub_wide[WIDTH-1:0];
                alu_c   = sub_wide[WIDTH];
                alu_v   = (opnd_a[WIDTH-1] != opnd_b[WIDTH-1]) &&
                          (sub_wide[WIDTH-1] != opnd_a[WIDTH-1]);
            end
            ALU_AND: alu_res = opnd_a & opnd_b;
            ALU_OR:  alu_res = opnd_a | opnd_b;
            ALU_XOR: alu_res = opnd_a ^ opnd_b;
            ALU_SLL: begin
                alu_res = sll_wide[WIDTH-1:0];
                alu_c   = sll_wide[WIDTH];
            end
            ALU_SLR: begin
                alu_res = rot_res;
                alu_c   = (shamt != 4'd0) && rot_res[WIDTH-1];
            end
            ALU_SRL: begin
                alu_res = srl_wide[WIDTH:1];
                alu_c   = srl_wide[0];
            end
            ALU_SRA: begin
                alu_res = sra_wide[WIDTH:1];
                alu_c   = sra_wide[0];
            end
            default: alu_res = opnd_b;
        endcase
    end

    assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

    // MOV, MUL and unassigned codes leave the flag register alone.
    assign flag_op = (op_alu_ex <= ALU_CMP) ||
                     ((op_alu_ex >= ALU_SLL) && (op_alu_ex <= ALU_SRA));

    // ------------------------------------------------------------------
    // Multi-cycle multiply
    // ------------------------------------------------------------------
    logic             stall_int;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

`ifdef EX_MUL_EN
    localparam logic [3:0] ALU_MUL = 4'd12;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    mul_state_t       mul_state;
    mul_state_t       mul_state_next;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [3:0]       mul_count;

    // Multiplier state register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) mul_state <= MUL_IDLE;
        else       mul_state <= mul_state_next;
    end

    // Next state and stall request; a flush aborts from any state.
    always_comb begin
        mul_state_next = mul_state;
        stall_int      = 1'b0;
        case (mul_state)
            MUL_IDLE: begin
                if (op_alu_ex == ALU_MUL) begin
                    stall_int      = 1'b1;
                    mul_state_next = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                stall_int = 1'b1;
                if (mul_count == 4'd15) mul_state_next = MUL_DONE;
            end
            MUL_DONE: begin
                if (ex_mem_write) mul_state_next = MUL_IDLE;
            end
            default: mul_state_next = MUL_IDLE;
        endcase
        if (flush) mul_state_next = MUL_IDLE;
    end

    // Shift-add datapath: capture operands while idle, one bit per BUSY cycle.
    always_ff @(posedge clock) begin
        // NOTE: these working registers are reloaded in IDLE before every
        // multiply and are never observed otherwise, so they carry no reset.
        if (mul_state == MUL_IDLE) begin
            mul_acc    <= '0;
            mul_mcand  <= opnd_a;
            mul_mplier <= opnd_b;
            mul_count  <= 4'd0;
        end else if (mul_state == MUL_BUSY) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_count  <= mul_count + 4'd1;
        end
    end

    assign mul_done    = (mul_state == MUL_DONE);
    assign mul_product = mul_acc;
`else
    assign stall_int   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // The hazard unit must not see a stall while the stage is held in reset.
    assign stall_ex = stall_int && !reset;

    // ------------------------------------------------------------------
    // EX/MEM pipeline register and flags
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ex_result;
    assign ex_result = mul_done ? mul_product : alu_res;

    // Priority: reset, flush (bubble), stall (hold), ex_mem_write=0 (hold), load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_mem_write_mem         <= 1'b0;
            op_mem_read_mem          <= 1'b0;
            op_reg_write_mem         <= 1'b0;
            op_reg_write_address_mem <= 1'b0;
            op_mdr_mem               <= 1'b0;
            op_res_mem               <= 1'b0;
            rd_mem                   <= 3'd0;
            alu_result_mem           <= '0;
            store_data_mem           <= '0;
            program_counter_pre_mem  <= '0;
            instruction_register_mem <= '0;
            flags                    <= 4'd0;
        end else if (flush) begin
            // A bubble clears the whole register so MEM sees a clean NOP;
            // flags belong to the retired stream and are kept.
            op_mem_write_mem         <= 1'b0;
            op_mem_read_mem          <= 1'b0;
            op_reg_write_mem         <= 1'b0;
            op_reg_write_address_mem <= 1'b0;
            op_mdr_mem               <= 1'b0;
            op_res_mem               <= 1'b0;
            rd_mem                   <= 3'd0;
            alu_result_mem           <= '0;
            store_data_mem           <= '0;
            program_counter_pre_mem  <= '0;
            instruction_register_mem <= '0;
        end else if (!stall_int && ex_mem_write) begin
            op_mem_write_mem         <= op_mem_write_ex;
            op_mem_read_mem          <= op_mem_read_ex;
            op_reg_write_mem         <= op_reg_write_ex && (op_alu_ex != ALU_CMP);
            op_reg_write_address_mem <= op_reg_write_address_ex;
            op_mdr_mem               <= op_mdr_ex;
            op_res_mem               <= op_res_ex;
            rd_mem                   <= rd_ex;
            alu_result_mem           <= ex_result;
            store_data_mem           <= fwd_b;
            program_counter_pre_mem  <= program_counter_pre_ex;
            instruction_register_mem <= instruction_register_ex;
            if (flag_op) flags <= alu_flags;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Directed-vector bench for ex_mem_stage. Each task drives one scenario and
// compares the registered outputs against hand-computed values.

module tb_ex_mem_stage;

    logic        clock;
    logic        reset;
    logic        ex_mem_write;
    logic        flush;
    logic [15:0] program_counter_pre_ex;
    logic [1:0]  op_alu_src_a_ex;
    logic [1:0]  op_alu_src_b_ex;
    logic [3:0]  op_alu_ex;
    logic        op_mem_write_ex;
    logic        op_mem_read_ex;
    logic        op_reg_write_ex;
    logic        op_reg_write_address_ex;
    logic        op_mdr_ex;
    logic        op_res_ex;
    logic [2:0]  rs_ex;
    logic [2:0]  rd_ex;
    logic [15:0] ar_ex;
    logic [15:0] br_ex;
    logic [15:0] instruction_register_ex;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] fwd_mem_data;
    logic [15:0] fwd_wb_data;

    logic        op_mem_write_mem;
    logic        op_mem_read_mem;
    logic        op_reg_write_mem;
    logic        op_reg_write_address_mem;
    logic        op_mdr_mem;
    logic        op_res_mem;
    logic [2:0]  rd_mem;
    logic [15:0] alu_result_mem;
    logic [15:0] store_data_mem;
    logic [15:0] program_counter_pre_mem;
    logic [15:0] instruction_register_mem;
    logic [3:0]  flags;
    logic        stall_ex;

    int vectors;
    int miscompares;

    logic [5:0] ctrl_mem;
    assign ctrl_mem = {op_mem_write_mem, op_mem_read_mem, op_reg_write_mem,
                       op_reg_write_address_mem, op_mdr_mem, op_res_mem};

    ex_mem_stage dut (
        .clock                    (clock),
        .reset                    (reset),
        .ex_mem_write             (ex_mem_write),
        .flush                    (flush),
        .program_counter_pre_ex   (program_counter_pre_ex),
        .op_alu_src_a_ex          (op_alu_src_a_ex),
        .op_alu_src_b_ex          (op_alu_src_b_ex),
        .op_alu_ex                (op_alu_ex),
        .op_mem_write_ex          (op_mem_write_ex),
        .op_mem_read_ex           (op_mem_read_ex),
        .op_reg_write_ex          (op_reg_write_ex),
        .op_reg_write_address_ex  (op_reg_write_address_ex),
        .op_mdr_ex                (op_mdr_ex),
        .op_res_ex                (op_res_ex),
        .rs_ex                    (rs_ex),
        .rd_ex                    (rd_ex),
        .ar_ex                    (ar_ex),
        .br_ex                    (br_ex),
        .instruction_register_ex  (instruction_register_ex),
        .fwd_a_sel                (fwd_a_sel),
        .fwd_b_sel                (fwd_b_sel),
        .fwd_mem_data             (fwd_mem_data),
        .fwd_wb_data              (fwd_wb_data),
        .op_mem_write_mem         (op_mem_write_mem),
        .op_mem_read_mem          (op_mem_read_mem),
        .op_reg_write_mem         (op_reg_write_mem),
        .op_reg_write_address_mem (op_reg_write_address_mem),
        .op_mdr_mem               (op_mdr_mem),
        .op_res_mem               (op_res_mem),
        .rd_mem                   (rd_mem),
        .alu_result_mem           (alu_result_mem),
        .store_data_mem           (store_data_mem),
        .program_counter_pre_mem  (program_counter_pre_mem),
        .instruction_register_mem (instruction_register_mem),
        .flags                    (flags),
        .stall_ex                 (stall_ex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t alu_vecs [15];

    // Inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_defaults();
        ex_mem_write            = 1'b1;
        flush                   = 1'b0;
        program_counter_pre_ex  = 16'h0010;
        op_alu_src_a_ex         = 2'b00;
        op_alu_src_b_ex         = 2'b00;
        op_alu_ex               = 4'd0;
        op_mem_write_ex         = 1'b1;
        op_mem_read_ex          = 1'b1;
        op_reg_write_ex         = 1'b1;
        op_reg_write_address_ex = 1'b1;
        op_mdr_ex               = 1'b1;
        op_res_ex               = 1'b1;
        rs_ex                   = 3'd2;
        rd_ex                   = 3'd5;
        ar_ex                   = 16'h0000;
        br_ex                   = 16'h0000;
        instruction_register_ex = 16'h0000;
        fwd_a_sel               = 2'b00;
        fwd_b_sel               = 2'b00;
        fwd_mem_data            = 16'h0000;
        fwd_wb_data             = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_defaults();
        #2;
        vectors++; if (ctrl_mem !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want %b", ctrl_mem, 6'b0); end
        vectors++; if (alu_result_mem !== 16'h0000) begin miscompares++; $display("FAIL reset_result got %h want 0000", alu_result_mem); end
        vectors++; if ({rd_mem, store_data_mem, program_counter_pre_mem, instruction_register_mem} !== 51'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", {rd_mem, store_data_mem, program_counter_pre_mem, instruction_register_mem}); end
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", flags); end
        vectors++; if (stall_ex !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_ex); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_add();
        set_defaults();
        ar_ex = 16'h7FFF; br_ex = 16'h5555; op_alu_src_b_ex = 2'b11;
        program_counter_pre_ex = 16'h0010; instruction_register_ex = 16'hA5C3;
        tick();
        vectors++; if (alu_result_mem !== 16'h8000) begin miscompares++; $display("FAIL add_result got %h want 8000", alu_result_mem); end
        vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL add_flags got %b want 1001", flags); end
        vectors++; if (ctrl_mem !== 6'b111111) begin miscompares++; $display("FAIL add_ctrl got %b want 111111", ctrl_mem); end
        vectors++; if (rd_mem !== 3'd5) begin miscompares++; $display("FAIL add_rd got %0d want 5", rd_mem); end
        vectors++; if (store_data_mem !== 16'h5555) begin miscompares++; $display("FAIL add_store got %h want 5555", store_data_mem); end
        vectors++; if (program_counter_pre_mem !== 16'h0010) begin miscompares++; $display("FAIL add_pc got %h want 0010", program_counter_pre_mem); end
        vectors++; if (instruction_register_mem !== 16'hA5C3) begin miscompares++; $display("FAIL add_ir got %h want a5c3", instruction_register_mem); end
        // carry out with zero result
        ar_ex = 16'hFFFF;
        tick();
        vectors++; if (alu_result_mem !== 16'h0000) begin miscompares++; $display("FAIL add_carry_result got %h want 0000", alu_result_mem); end
        vectors++; if (flags !== 4'b0110) begin miscompares++; $display("FAIL add_carry_flags got %b want 0110", flags); end
    endtask

    task automatic test_sub_cmp();
        set_defaults();
        op_alu_ex = 4'd1; ar_ex = 16'h0003; br_ex = 16'h0005;
        tick();
        vectors++; if (alu_result_mem !== 16'hFFFE) begin miscompares++; $display("FAIL sub_result got %h want fffe", alu_result_mem); end
        vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL sub_flags got %b want 1010", flags); end
        // signed overflow on subtract
        ar_ex = 16'h8000; br_ex = 16'h0001;
        tick();
        vectors++; if (alu_result_mem !== 16'h7FFF) begin miscompares++; $display("FAIL sub_ovf_result got %h want 7fff", alu_result_mem); end
        vectors++; if (flags !== 4'b0001) begin miscompares++; $display("FAIL sub_ovf_flags got %b want 0001", flags); end
        // CMP of equal values
        op_alu_ex = 4'd5; ar_ex = 16'h0042; br_ex = 16'h0042;
        tick();
        vectors++; if (flags !== 4'b0100) begin miscompares++; $display("FAIL cmp_flags got %b want 0100", flags); end
        vectors++; if (op_reg_write_mem !== 1'b0) begin miscompares++; $display("FAIL cmp_reg_write got %b want 0", op_reg_write_mem); end
        vectors++; if (op_mem_read_mem !== 1'b1) begin miscompares++; $display("FAIL cmp_mem_read got %b want 1", op_mem_read_mem); end
    endtask

    task automatic test_forward();
        set_defaults();
        fwd_a_sel = 2'b01; fwd_mem_data = 16'h1234; ar_ex = 16'h0000;
        fwd_b_sel = 2'b10; fwd_wb_data = 16'hBEEF; br_ex = 16'h1111;
        op_alu_src_b_ex = 2'b10; instruction_register_ex = 16'h0000;
        tick();
        vectors++; if (alu_result_mem !== 16'h1234) begin miscompares++; $display("FAIL fwd_a_result got %h want 1234", alu_result_mem); end
        vectors++; if (store_data_mem !== 16'hBEEF) begin miscompares++; $display("FAIL fwd_b_store got %h want beef", store_data_mem); end
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL fwd_flags got %b want 0000", flags); end
        // PC + sign-extended immediate
        set_defaults();
        op_alu_src_a_ex = 2'b01; program_counter_pre_ex = 16'h0100;
        op_alu_src_b_ex = 2'b01; instruction_register_ex = 16'h12FE;
        tick();
        vectors++; if (alu_result_mem !== 16'h00FE) begin miscompares++; $display("FAIL pc_sext_result got %h want 00fe", alu_result_mem); end
        vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL pc_sext_flags got %b want 0010", flags); end
        // A forced to zero, B forwarded from MEM
        set_defaults();
        op_alu_src_a_ex = 2'b10; ar_ex = 16'h7777;
        fwd_b_sel = 2'b01; fwd_mem_data = 16'h00F0;
        tick();
        vectors++; if (alu_result_mem !== 16'h00F0) begin miscompares++; $display("FAIL zero_a_result got %h want 00f0", alu_result_mem); end
        // fwd select 11 falls back to the register file
        set_defaults();
        fwd_a_sel = 2'b11; fwd_mem_data = 16'h4444; ar_ex = 16'h0007; op_alu_src_b_ex = 2'b11;
        tick();
        vectors++; if (alu_result_mem !== 16'h0008) begin miscompares++; $display("FAIL fwd_11_result got %h want 0008", alu_result_mem); end
    endtask

    task automatic test_logic_shift();
        alu_vecs = '{
            '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000},
            '{4'd3,  16'hF000, 16'h000F, 16'hF00F, 4'b1000},
            '{4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100},
            '{4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0010},
            '{4'd8,  16'h8000, 16'h0000, 16'h8000, 4'b1000},
            '{4'd8,  16'h0001, 16'h0010, 16'h0001, 4'b0000},
            '{4'd9,  16'h4000, 16'h0001, 16'h8000, 4'b1010},
            '{4'd9,  16'h8001, 16'h0004, 16'h0018, 4'b0000},
            '{4'd10, 16'h0003, 16'h0001, 16'h0001, 4'b0010},
            '{4'd11, 16'h8000, 16'h0004, 16'hF800, 4'b1000},
            '{4'd11, 16'h8008, 16'h0004, 16'hF800, 4'b1010},
            '{4'd10, 16'h8000, 16'h000F, 16'h0001, 4'b0000},
            '{4'd8,  16'hFFFF, 16'h000F, 16'h8000, 4'b1010},
            '{4'd6,  16'h1234, 16'h00AB, 16'h00AB, 4'b1010},
            '{4'd7,  16'h1234, 16'h0000, 16'h0000, 4'b1010}
        };
        set_defaults();
        for (int i = 0; i < 15; i++) begin
            op_alu_ex = alu_vecs[i].op;
            ar_ex     = alu_vecs[i].a;
            br_ex     = alu_vecs[i].b;
            tick();
            vectors++; if (alu_result_mem !== alu_vecs[i].res) begin miscompares++; $display("FAIL alu_vec%0d_result got %h want %h", i, alu_result_mem, alu_vecs[i].res); end
            vectors++; if (flags !== alu_vecs[i].flg) begin miscompares++; $display("FAIL alu_vec%0d_flags got %b want %b", i, flags, alu_vecs[i].flg); end
        end
    endtask

    task automatic test_hold_flush();
        set_defaults();
        op_alu_ex = 4'd1; ar_ex = 16'h0003; br_ex = 16'h0005; rd_ex = 3'd6;
        tick();
        ex_mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_alu_ex = 4'd0; ar_ex = 16'h7FFF + 16'(i); br_ex = 16'h0001;
            rd_ex = 3'(i); op_mem_read_ex = 1'b0;
            tick();
            vectors++; if (alu_result_mem !== 16'hFFFE) begin miscompares++; $display("FAIL hold%0d_result got %h want fffe", i, alu_result_mem); end
            vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL hold%0d_flags got %b want 1010", i, flags); end
            vectors++; if (rd_mem !== 3'd6 || op_mem_read_mem !== 1'b1) begin miscompares++; $display("FAIL hold%0d_ctrl got rd=%0d rd_en=%b want rd=6 rd_en=1", i, rd_mem, op_mem_read_mem); end
        end
        // bubble wins over hold; flags must survive it
        flush = 1'b1; ar_ex = 16'h7FFF;
        tick();
        vectors++; if (ctrl_mem !== 6'b0 || rd_mem !== 3'd0) begin miscompares++; $display("FAIL flush_ctrl got %b/%0d want 000000/0", ctrl_mem, rd_mem); end
        vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL flush_flags got %b want 1010", flags); end
        flush = 1'b0; ex_mem_write = 1'b1;
    endtask

    task automatic test_reset_mid();
        set_defaults();
        ar_ex = 16'h7FFF; op_alu_src_b_ex = 2'b11;
        tick();
`ifdef EX_MUL_EN
        op_alu_ex = 4'd12; ar_ex = 16'h0012; br_ex = 16'h0034; op_alu_src_b_ex = 2'b00;
        tick(); tick(); tick();
`endif
        reset = 1'b1;
        #1;
        vectors++; if (ctrl_mem !== 6'b0) begin miscompares++; $display("FAIL rst_mid_ctrl got %b want 000000", ctrl_mem); end
        vectors++; if (alu_result_mem !== 16'h0000 || flags !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_data got %h/%b want 0000/0000", alu_result_mem, flags); end
        vectors++; if (stall_ex !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall got %b want 0", stall_ex); end
        set_defaults();
        tick();
        reset = 1'b0;
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int stall_cycles;
        set_defaults();
        ar_ex = 16'h0005; op_alu_src_b_ex = 2'b11;
        tick();
        op_alu_ex = 4'd12; ar_ex = 16'h0012; br_ex = 16'h0034; op_alu_src_b_ex = 2'b00;
        #1;
        stall_cycles = 0;
        while (stall_ex === 1'b1 && stall_cycles < 40) begin
            stall_cycles++;
            tick();
        end
        vectors++; if (stall_cycles !== 17) begin miscompares++; $display("FAIL mul_stall_cycles got %0d want 17", stall_cycles); end
        vectors++; if (alu_result_mem !== 16'h0006) begin miscompares++; $display("FAIL mul_held_result got %h want 0006", alu_result_mem); end
        tick();
        vectors++; if (alu_result_mem !== 16'h03A8) begin miscompares++; $display("FAIL mul_product got %h want 03a8", alu_result_mem); end
        vectors++; if (flags !== 4'b0000 || op_reg_write_mem !== 1'b1) begin miscompares++; $display("FAIL mul_flags_ctrl got %b/%b want 0000/1", flags, op_reg_write_mem); end
        // abort on BUSY cycle 5
        ar_ex = 16'h0012; br_ex = 16'h0034;
        for (int i = 0; i < 5; i++) tick();
        vectors++; if (stall_ex !== 1'b1) begin miscompares++; $display("FAIL mul_busy_stall got %b want 1", stall_ex); end
        flush = 1'b1;
        tick();
        vectors++; if (ctrl_mem !== 6'b0 || alu_result_mem !== 16'h0000) begin miscompares++; $display("FAIL mul_abort_bubble got %b/%h want 000000/0000", ctrl_mem, alu_result_mem); end
        flush = 1'b0; op_alu_ex = 4'd0;
        #1;
        vectors++; if (stall_ex !== 1'b0) begin miscompares++; $display("FAIL mul_abort_idle got %b want 0", stall_ex); end
        tick();
        vectors++; if (alu_result_mem !== 16'h0046) begin miscompares++; $display("FAIL mul_after_abort got %h want 0046", alu_result_mem); end
    endtask
`else
    task automatic test_mul();
        set_defaults();
        op_alu_ex = 4'd12; ar_ex = 16'h0012; br_ex = 16'h0034;
        #1;
        vectors++; if (stall_ex !== 1'b0) begin miscompares++; $display("FAIL mul_off_stall got %b want 0", stall_ex); end
        tick();
        vectors++; if (alu_result_mem !== 16'h0034) begin miscompares++; $display("FAIL mul_off_result got %h want 0034", alu_result_mem); end
        vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL mul_off_flags got %b want 1010", flags); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_forward();
        test_logic_shift();
        test_hold_flush();
        test_mul();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
